// File: rtl/led_blinker_pkg.sv
// Shared address map, channel state encoding and channel config payload for led_blinker_array.
package led_blinker_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] ADDR_ID      = 32'd0;
  localparam logic [31:0] ADDR_GLOBAL  = 32'd1;
  localparam logic [31:0] ADDR_SCRATCH = 32'd2;
  localparam logic [31:0] ADDR_NUM_CH  = 32'd3;
  localparam logic [31:0] CH_BASE      = 32'd8;
  localparam logic [31:0] CH_STRIDE    = 32'd4;

  localparam logic [1:0] CH_CTRL    = 2'd0;
  localparam logic [1:0] CH_PERIOD  = 2'd1;
  localparam logic [1:0] CH_ON_TIME = 2'd2;
  localparam logic [1:0] CH_COUNT   = 2'd3;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_ON   = 2'd1,
    CH_OFF  = 2'd2
  } ch_state_e;

  // Programmed (shadow) view of one channel, as seen by the host.
  typedef struct packed {
    logic              en;
    logic              invert;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] on_time;
  } ch_cfg_t;

endpackage

// File: rtl/led_blinker_channel.sv
// One blink channel: control/shadow registers, active period copies, IDLE/ON/OFF FSM,
// free-running counter and registered, optionally inverted LED output.
module led_blinker_channel
  import led_blinker_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              global_en_i,
  input  logic              sync_restart_i,
  input  logic              wr_ctrl_i,
  input  logic              wr_period_i,
  input  logic              wr_on_time_i,
  input  logic [DATA_W-1:0] wdata_i,
  output ch_cfg_t           cfg_o,
  output logic [DATA_W-1:0] count_o,
  output logic              led_o
);

  ch_state_e        state_q, state_d;
  logic             en_q, en_d, inv_q, inv_d, led_q, led_d;
  logic [CNT_W-1:0] per_sh_q, per_sh_d, on_sh_q, on_sh_d;
  logic [CNT_W-1:0] per_q, per_d, on_q, on_d, cnt_q, cnt_d;
  logic             run_ok_c, wrap_c;

  assign run_ok_c = en_q && global_en_i && (per_sh_q != '0);
  assign wrap_c   = (cnt_q == per_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CH_IDLE;
      en_q     <= 1'b0;
      inv_q    <= 1'b0;
      led_q    <= 1'b0;
      per_sh_q <= '0;
      on_sh_q  <= '0;
      per_q    <= '0;
      on_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      inv_q    <= inv_d;
      led_q    <= led_d;
      per_sh_q <= per_sh_d;
      on_sh_q  <= on_sh_d;
      per_q    <= per_d;
      on_q     <= on_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    inv_d    = inv_q;
    per_sh_d = per_sh_q;
    on_sh_d  = on_sh_q;
    per_d    = per_q;
    on_d     = on_q;
    cnt_d    = cnt_q;
    led_d    = (state_q == CH_ON) ^ inv_q;

    if (wr_ctrl_i) begin
      en_d  = wdata_i[0];
      inv_d = wdata_i[1];
    end
    if (wr_period_i)  per_sh_d = CNT_W'(wdata_i);
    if (wr_on_time_i) on_sh_d  = CNT_W'(wdata_i);

    case (state_q)
      CH_IDLE: begin
        cnt_d = '0;
        per_d = per_sh_q;
        on_d  = on_sh_q;
        if (run_ok_c) state_d = (on_sh_q != '0) ? CH_ON : CH_OFF;
      end
      CH_ON, CH_OFF: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == CH_ON && cnt_q == on_q - CNT_W'(1) && on_q < per_q) state_d = CH_OFF;
        // Period boundary (or phase-align request): reload shadows and start a new period.
        if (wrap_c || sync_restart_i) begin
          cnt_d   = '0;
          per_d   = per_sh_q;
          on_d    = on_sh_q;
          state_d = (on_sh_q != '0) ? CH_ON : CH_OFF;
        end
      end
      default: state_d = CH_IDLE;
    endcase

    if (!run_ok_c) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
    end
  end

  assign cfg_o.en      = en_q;
  assign cfg_o.invert  = inv_q;
  assign cfg_o.period  = DATA_W'(per_sh_q);
  assign cfg_o.on_time = DATA_W'(on_sh_q);
  assign count_o       = DATA_W'(cnt_q);
  assign led_o         = led_q;

endmodule

// File: rtl/led_blinker_array.sv
// Multi-channel LED blinker behind an Avalon-MM slave: register decode, readback mux, channel array.
// Optional build macro LED_BLINKER_SYNC_RESTART_EN enables the GLOBAL bit1 phase-align pulse.
module led_blinker_array
  import led_blinker_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       master_mm_address,
  input  logic              master_mm_read,
  input  logic              master_mm_write,
  input  logic [31:0]       master_mm_writedata,
  output logic [31:0]       master_mm_readdata,
  output logic              master_mm_readdatavalid,
  output logic              master_mm_waitrequest,
  output logic [NUM_CH-1:0] led_active
);

  localparam int unsigned CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] CH_END   = CH_BASE + CH_STRIDE * 32'(NUM_CH);

  logic                waitreq_q, global_en_q, global_en_d, rvalid_q, rvalid_d;
  logic [31:0]         scratch_q, scratch_d, rdata_q, rdata_d, rd_mux_c;
  logic                acc_rd_c, acc_wr_c, is_ch_c, sync_c;
  logic [CH_IDX_W-1:0] ch_idx_c;
  logic [1:0]          ch_off_c;
  logic [NUM_CH-1:0]   wr_ctrl_c, wr_period_c, wr_on_c, led_c;
  ch_cfg_t             cfg_c [NUM_CH];
  logic [DATA_W-1:0]   cnt_c [NUM_CH];

  assign acc_rd_c = master_mm_read  && !waitreq_q;
  assign acc_wr_c = master_mm_write && !waitreq_q;
  assign is_ch_c  = (master_mm_address >= CH_BASE) && (master_mm_address < CH_END);
  assign ch_idx_c = CH_IDX_W'((master_mm_address - CH_BASE) >> 2);
  assign ch_off_c = 2'(master_mm_address - CH_BASE);

`ifdef LED_BLINKER_SYNC_RESTART_EN
  assign sync_c = acc_wr_c && (master_mm_address == ADDR_GLOBAL) && master_mm_writedata[1];
`else
  assign sync_c = 1'b0;
`endif

  always_comb begin
    wr_ctrl_c   = '0;
    wr_period_c = '0;
    wr_on_c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (acc_wr_c && is_ch_c && ch_idx_c == CH_IDX_W'(i)) begin
        wr_ctrl_c[i]   = (ch_off_c == CH_CTRL);
        wr_period_c[i] = (ch_off_c == CH_PERIOD);
        wr_on_c[i]     = (ch_off_c == CH_ON_TIME);
      end
    end
  end

  // Readback reflects register state before any same-cycle write.
  always_comb begin
    rd_mux_c = '0;
    if (is_ch_c) begin
      case (ch_off_c)
        CH_CTRL:    rd_mux_c = {30'b0, cfg_c[ch_idx_c].invert, cfg_c[ch_idx_c].en};
        CH_PERIOD:  rd_mux_c = cfg_c[ch_idx_c].period;
        CH_ON_TIME: rd_mux_c = cfg_c[ch_idx_c].on_time;
        default:    rd_mux_c = cnt_c[ch_idx_c];
      endcase
    end else begin
      case (master_mm_address)
        ADDR_ID:      rd_mux_c = VERSION;
        ADDR_GLOBAL:  rd_mux_c = {31'b0, global_en_q};
        ADDR_SCRATCH: rd_mux_c = scratch_q;
        ADDR_NUM_CH:  rd_mux_c = 32'(NUM_CH);
        default:      rd_mux_c = '0;
      endcase
    end
  end

  always_comb begin
    global_en_d = global_en_q;
    scratch_d   = scratch_q;
    if (acc_wr_c && master_mm_address == ADDR_GLOBAL)  global_en_d = master_mm_writedata[0];
    if (acc_wr_c && master_mm_address == ADDR_SCRATCH) scratch_d   = master_mm_writedata;
    rdata_d  = acc_rd_c ? rd_mux_c : '0;
    rvalid_d = acc_rd_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitreq_q   <= 1'b1;
      global_en_q <= 1'b0;
      scratch_q   <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      waitreq_q   <= 1'b0;
      global_en_q <= global_en_d;
      scratch_q   <= scratch_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_blinker_channel #(.CNT_W(CNT_W)) u_ch (
      .clk            (clk),
      .rst            (rst),
      .global_en_i    (global_en_q),
      .sync_restart_i (sync_c),
      .wr_ctrl_i      (wr_ctrl_c[g]),
      .wr_period_i    (wr_period_c[g]),
      .wr_on_time_i   (wr_on_c[g]),
      .wdata_i        (master_mm_writedata),
      .cfg_o          (cfg_c[g]),
      .count_o        (cnt_c[g]),
      .led_o          (led_c[g])
    );
  end

  assign master_mm_readdata      = rdata_q;
  assign master_mm_readdatavalid = rvalid_q;
  assign master_mm_waitrequest   = waitreq_q;
  assign led_active              = led_c;

endmodule

// File: doc/led_blinker_array.md
Name: led_blinker_array

Overview:
- Parametrised multi-channel successor to the single-LED controller. Drives NUM_CH LEDs, each with an independent blink period, on-time and polarity.
- All settings are programmed over the existing Avalon-MM slave port from the host bridge. Sits between the MM interconnect and the board LED pins.
- Adds behaviour the single-LED block lacks:
  - real per-channel blink counters;
  - glitch-free shadowed updates;
  - correct one-cycle readdatavalid pulses.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- CNT_W, 32, width of the period/on-time counters in clk cycles.
- VERSION, 32'h0002_0000, read-only value at the ID register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- master_mm_address  in  32  word address
- master_mm_read  in  1  read strobe
- master_mm_write  in  1  write strobe
- master_mm_writedata  in  32  write data
- master_mm_readdata  out  32  read data
- master_mm_readdatavalid  out  1  one-cycle read-data qualifier
- master_mm_waitrequest  out  1  stall
- led_active  out  NUM_CH  LED drive, bit i = channel i

Behaviour:
- Reset: one clock clk; rst is asynchronous, active-low.
  - All registers clear.
  - led_active = 0, readdata = 0, readdatavalid = 0, waitrequest = 1.
  - waitrequest falls to 0 on the first clk edge after rst deasserts and then stays 0; every access is accepted in one cycle.
- Address map (word addresses):
  - 0 ID (RO, VERSION).
  - 1 GLOBAL: bit0 global_en, bit1 sync_restart (write-1 pulse, reads 0).
  - 2 SCRATCH (RW 32b).
  - 3 NUM_CH (RO).
  - Channel i base = 8+4*i:
    - +0 CTRL: bit0 en, bit1 invert.
    - +1 PERIOD (CNT_W).
    - +2 ON_TIME (CNT_W).
    - +3 COUNT (RO, live counter).
- Unmapped addresses: writes ignored; reads return 0 with a valid pulse.
- Read timing: latency exactly 1. readdatavalid = 1 for exactly the cycle after an accepted read, 0 otherwise.
- Read and write in the same cycle: both are performed; the read returns the pre-write value.
- Channel FSM states: IDLE, ON, OFF.
  - IDLE: counter = 0, raw LED = 0.
  - IDLE -> ON when en & global_en & PERIOD != 0 & ON_TIME != 0.
  - IDLE -> OFF when the same conditions hold but ON_TIME = 0.
  - Counter increments every cycle in ON/OFF.
  - ON -> OFF when the counter reaches ON_TIME-1, unless ON_TIME >= PERIOD, in which case the channel stays ON.
  - At counter = PERIOD-1 the counter wraps to 0 and the state re-enters ON (or OFF if ON_TIME = 0).
  - Any state -> IDLE within 1 cycle when en = 0, global_en = 0, or PERIOD = 0.
- Shadowing: PERIOD and ON_TIME writes land in shadow registers.
  - Active copies load at the wrap cycle, or immediately when in IDLE.
  - Readback returns the shadow values.
- Output: led_active[i] = raw LED XOR invert, registered. This gives 1 cycle of latency from a state change.
- Counter arithmetic: unsigned CNT_W; no overflow is possible because the counter is bounded by PERIOD-1.
- Reset mid-operation forces every channel to IDLE asynchronously.

Optional Feature:
- Macro: LED_BLINKER_SYNC_RESTART_EN.
- Defined: writing GLOBAL bit1 = 1 zeroes all running channel counters in the same cycle, loads the shadow registers, and enters ON (or OFF if ON_TIME = 0). This phase-aligns all channels.
- Undefined: bit1 is ignored and the channels free-run independently.

Decomposition:
- Package led_blinker_pkg holds:
  - the address constants (ADDR_ID, ADDR_GLOBAL, ADDR_SCRATCH, ADDR_NUM_CH, CH_BASE, CH_STRIDE, CH_CTRL/PERIOD/ON_TIME/COUNT offsets);
  - the ch_state_e enum;
  - a ch_cfg_t struct {en, invert, period, on_time}.
- Sub-module led_blinker_channel, one per channel via generate, contains:
  - the FSM, counter, shadow registers, sync_restart input and the registered output.
- The top level keeps the MM decode and readback mux.

Test Plan:
- Reset check: hold rst = 0 → led_active = 0, waitrequest = 1; release rst → waitrequest = 0 after one edge; read addr 0 → readdata = 32'h0002_0000, valid for exactly 1 cycle.
- Basic blink: ch0 PERIOD = 10, ON_TIME = 3, en = 1, global_en = 1 → led_active[0] repeats high 3 / low 7 cycles; the other channels stay 0.
- Invert and edge cases: ch1 invert = 1, en = 0 → led_active[1] = 1. ch2 ON_TIME = 12, PERIOD = 10 → constant 1. ch3 PERIOD = 0 → IDLE, output 0.
- Shadow update: ch0 running at 10/3; write PERIOD = 4 at counter = 5 → the old waveform completes to the wrap, then 3 high / 1 low; readback of PERIOD = 4 immediately.
- Bus rules: simultaneous read and write to SCRATCH → read returns the old value; read addr 0x7F → readdata 0 with one valid pulse; no readdatavalid without a read.
- With LED_BLINKER_SYNC_RESTART_EN: ch0 and ch1 both at 8/4 with offset phases; write GLOBAL = 3 → both COUNT registers = 0 on the same cycle and the outputs are identical afterwards.
